// File: rtl/coherence_pkg.sv
// Shared types for the MSI coherence directory: directory line state,
// request/snoop opcodes and the controller FSM encoding.
package coherence_pkg;

   typedef enum logic [1:0] {
      DIR_I = 2'd0,
      DIR_S = 2'd1,
      DIR_M = 2'd2
   } dir_state_e;

   typedef enum logic [1:0] {
      OP_GETS = 2'b00,
      OP_GETM = 2'b01,
      OP_PUTM = 2'b10,
      OP_RSVD = 2'b11
   } req_op_e;

   typedef enum logic {
      SNP_INV   = 1'b0,
      SNP_FETCH = 1'b1
   } snoop_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_SNOOP,
      ST_MEMRD,
      ST_MEMWR,
      ST_RESP
   } fsm_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: the search starts at ptr, which moves to the
// core after the winner whenever a grant is taken.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic                 advance,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grantIdx
);
   localparam int PW = $clog2(N);

   logic [PW-1:0] ptr;
   logic [PW:0]   cand;
   logic          found;

   // first requester at or after ptr, wrapping modulo N
   always_comb begin
      grant    = '0;
      grantIdx = '0;
      found    = 1'b0;
      cand     = '0;
      for (int i = 0; i < N; i++) begin
         cand = {1'b0, ptr} + (PW+1)'(i);
         if (cand >= (PW+1)'(N)) cand = cand - (PW+1)'(N);
         if (!found && req[cand[PW-1:0]]) begin
            found                 = 1'b1;
            grant[cand[PW-1:0]]   = 1'b1;
            grantIdx              = cand[PW-1:0];
         end
      end
   end

   // priority pointer moves past the core that just won
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          ptr <= '0;
      else if (advance) ptr <= (grantIdx == PW'(N-1)) ? '0 : grantIdx + PW'(1);
   end

endmodule

// File: rtl/coherence_directory.sv
// Full-map MSI directory controller for NUM_CORES private L1s.
// One request is in flight at a time: grant, lookup, optional snoop,
// optional memory access, then respond and update the entry.
// Optional: define COHDIR_STATS_EN to add request / snoop counters.
module coherence_directory
   import coherence_pkg::*;
#(
   parameter int NUM_CORES = 4,
   parameter int LINE_AW   = 4,
   parameter int DATA_W    = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CORES-1:0]          req_valid,
   output logic [NUM_CORES-1:0]          req_ready,
   input  logic [2*NUM_CORES-1:0]        req_op,
   input  logic [NUM_CORES*LINE_AW-1:0]  req_addr,
   input  logic [NUM_CORES*DATA_W-1:0]   req_data,
   output logic [NUM_CORES-1:0]          resp_valid,
   output logic [DATA_W-1:0]             resp_data,
   output logic [NUM_CORES-1:0]          snoop_valid,
   output logic                          snoop_op,
   output logic [LINE_AW-1:0]            snoop_addr,
   input  logic [NUM_CORES-1:0]          snoop_ack,
   input  logic [NUM_CORES*DATA_W-1:0]   snoop_data,
   output logic                          mem_req_valid,
   output logic                          mem_we,
   output logic [LINE_AW-1:0]            mem_addr,
   output logic [DATA_W-1:0]             mem_wdata,
   input  logic                          mem_ready,
   input  logic                          mem_rvalid,
   input  logic [DATA_W-1:0]             mem_rdata
`ifdef COHDIR_STATS_EN
   ,
   output logic [31:0]                   stat_req_cnt,
   output logic [31:0]                   stat_inval_cnt
`endif
);
   localparam int CW    = $clog2(NUM_CORES);
   localparam int LINES = 1 << LINE_AW;

   fsm_state_e             state, nextState, afterSnoop, planNext, planAfter;
   dir_state_e             dirState [LINES];
   logic [NUM_CORES-1:0]   dirSharers [LINES];
   dir_state_e             entState, updState, planSt;
   logic [NUM_CORES-1:0]   entSharers, updSharers, planSh, planSnoop;
   logic [NUM_CORES-1:0]   grant, reqBit, invTargets, snoopPend;
   logic [CW-1:0]          grantIdx, curCore;
   logic [1:0]             grantOp;
   req_op_e                curOp;
   logic [LINE_AW-1:0]     curAddr;
   logic [DATA_W-1:0]      curData, lineData;
   logic                   snoopFetch, memIssued, updEn, planUpd, planFetch, ownerOther, grantTaken;

   assign grantTaken = (state == ST_IDLE) && (|req_valid);
   assign grantOp    = req_op[{grantIdx, 1'b0} +: 2];
   assign reqBit     = NUM_CORES'(1) << curCore;
   assign entState   = dirState[curAddr];
   assign entSharers = dirSharers[curAddr];
   assign ownerOther = (entState == DIR_M) && (entSharers != reqBit);
   assign invTargets = entSharers & ~reqBit;

   rr_arbiter #(.N(NUM_CORES)) uArb (
      .clk      (clk),
      .rst      (rst),
      .req      (req_valid),
      .advance  (grantTaken),
      .grant    (grant),
      .grantIdx (grantIdx)
   );

   // decide the transaction path and the final entry value from the lookup
   always_comb begin
      planNext  = ST_MEMRD;
      planAfter = ST_MEMRD;
      planSnoop = '0;
      planFetch = 1'b0;
      planUpd   = 1'b1;
      planSt    = entState;
      planSh    = entSharers;
      case (curOp)
         OP_GETM: begin
            planSt = DIR_M;
            planSh = reqBit;
            if (ownerOther) begin
               planNext  = ST_SNOOP;
               planSnoop = entSharers;
               planFetch = 1'b1;
               planAfter = ST_RESP;
            end else if (entState == DIR_S && invTargets != '0) begin
               planNext  = ST_SNOOP;
               planSnoop = invTargets;
            end
         end
         OP_PUTM: begin
            if (entState == DIR_M && !ownerOther) begin
               planNext = ST_MEMWR;
               planSt   = DIR_I;
               planSh   = '0;
            end else begin
               planNext = ST_RESP;
               planUpd  = 1'b0;
            end
         end
         default: begin
            if (ownerOther) begin
               // owner's dirty data goes back to memory and to the reader
               planNext  = ST_SNOOP;
               planSnoop = entSharers;
               planFetch = 1'b1;
               planAfter = ST_MEMWR;
               planSt    = DIR_S;
               planSh    = entSharers | reqBit;
            end else if (entState == DIR_M) begin
               planUpd = 1'b0;
            end else begin
               planSt = DIR_S;
               planSh = entSharers | reqBit;
            end
         end
      endcase
   end

   // controller state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= nextState;
   end

   // next state and handshake outputs
   always_comb begin
      nextState     = state;
      req_ready     = '0;
      resp_valid    = '0;
      snoop_valid   = '0;
      mem_req_valid = 1'b0;
      case (state)
         ST_IDLE: if (|req_valid) begin
            req_ready = grant;
            nextState = ST_LOOKUP;
         end
         ST_LOOKUP: nextState = planNext;
         ST_SNOOP: begin
            snoop_valid = snoopPend;
            if ((snoopPend & ~snoop_ack) == '0) nextState = afterSnoop;
         end
         ST_MEMRD: begin
            mem_req_valid = !memIssued;
            if (memIssued && mem_rvalid) nextState = ST_RESP;
         end
         ST_MEMWR: begin
            mem_req_valid = 1'b1;
            if (mem_ready) nextState = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = reqBit;
            nextState  = ST_IDLE;
         end
         default: nextState = ST_IDLE;
      endcase
   end

   assign snoop_op   = snoopFetch;
   assign snoop_addr = curAddr;
   assign mem_we     = (state == ST_MEMWR);
   assign mem_addr   = curAddr;
   assign mem_wdata  = (curOp == OP_PUTM) ? curData : lineData;
   assign resp_data  = (state == ST_RESP) ? lineData : '0;

   // request latch, snoop tracking, memory handshake and directory update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         curCore    <= '0;
         curOp      <= OP_GETS;
         curAddr    <= '0;
         curData    <= '0;
         lineData   <= '0;
         snoopPend  <= '0;
         snoopFetch <= 1'b0;
         afterSnoop <= ST_MEMRD;
         memIssued  <= 1'b0;
         updEn      <= 1'b0;
         updState   <= DIR_I;
         updSharers <= '0;
         for (int i = 0; i < LINES; i++) begin
            dirState[i]   <= DIR_I;
            dirSharers[i] <= '0;
         end
      end else begin
         case (state)
            ST_IDLE: if (|req_valid) begin
               curCore <= grantIdx;
               curOp   <= (grantOp == 2'b11) ? OP_GETS : req_op_e'(grantOp);
               curAddr <= req_addr[int'(grantIdx)*LINE_AW +: LINE_AW];
               curData <= req_data[int'(grantIdx)*DATA_W +: DATA_W];
            end
            ST_LOOKUP: begin
               snoopPend  <= planSnoop;
               snoopFetch <= planFetch;
               afterSnoop <= planAfter;
               updEn      <= planUpd;
               updState   <= planSt;
               updSharers <= planSh;
               lineData   <= '0;
               memIssued  <= 1'b0;
            end
            ST_SNOOP: begin
               snoopPend <= snoopPend & ~snoop_ack;
               for (int c = 0; c < NUM_CORES; c++)
                  if (snoopFetch && snoopPend[c] && snoop_ack[c])
                     lineData <= snoop_data[c*DATA_W +: DATA_W];
            end
            ST_MEMRD: begin
               if (!memIssued && mem_ready) memIssued <= 1'b1;
               if (memIssued && mem_rvalid) lineData <= mem_rdata;
            end
            ST_RESP: if (updEn) begin
               dirState[curAddr]   <= updState;
               dirSharers[curAddr] <= updSharers;
            end
            default: ;
         endcase
      end
   end

`ifdef COHDIR_STATS_EN
   logic [32:0] reqSum, invSum;
   assign reqSum = {1'b0, stat_req_cnt} + 33'd1;
   assign invSum = {1'b0, stat_inval_cnt} + 33'($countones(planSnoop));

   // saturating counts of accepted requests and per-core snoops issued
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_req_cnt   <= '0;
         stat_inval_cnt <= '0;
      end else begin
         if (grantTaken)          stat_req_cnt   <= reqSum[32] ? '1 : reqSum[31:0];
         if (state == ST_LOOKUP)  stat_inval_cnt <= invSum[32] ? '1 : invSum[31:0];
      end
   end
`endif

endmodule
